// File: rtl/blink_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// blink_meter: measures high/low phase lengths of a slow toggling input
// rev 1.0
// ----------------------------------------------------------------------------
module blink_meter #(
  parameter int CNT_W   = 32,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 100000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] HALF_PERIOD,
  output logic             LEVEL,
  output logic             VALID,
  output logic             TIMEOUT_FLAG,
  output logic [1:0]       LED
);

  localparam int              FW        = $clog2(FILTER + 1);
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER - 1);
  localparam logic [FW-1:0]   FILT_ONE  = FW'(1);
  localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_ACQUIRE = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_STALLED = 2'd2;

  logic             sync1_q, sync2_q;
  logic [FW-1:0]    filt_cnt_q, filt_cnt_d;
  logic             level_q, level_d;
  logic             edge_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic             lvl_q, lvl_d;
  logic             valid_q, valid_d;
  logic             flag_q, flag_d;

  // A differing sample that falls back to the old level restarts the count.
  always_comb begin
    filt_cnt_d = '0;
    level_d    = level_q;
    edge_d     = 1'b0;
    if (sync2_q != level_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        edge_d  = 1'b1;
        level_d = sync2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FILT_ONE;
      end
    end
  end

  // Counter holds cycles since the edge minus one, so elapsed equals N at the next edge.
  assign elapsed = cnt_q + CNT_ONE;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_cnt_q <= '0;
      level_q    <= 1'b0;
      state_q    <= S_ACQUIRE;
      cnt_q      <= '0;
      hp_q       <= '0;
      lvl_q      <= 1'b0;
      valid_q    <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      sync1_q    <= SIG_IN;
      sync2_q    <= sync1_q;
      filt_cnt_q <= filt_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hp_q       <= hp_d;
      lvl_q      <= lvl_d;
      valid_q    <= valid_d;
      flag_q     <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ACQUIRE: if (edge_d) state_d = S_MEASURE;
      S_MEASURE: if (!edge_d && elapsed == TMO) state_d = S_STALLED;
      S_STALLED: if (edge_d) state_d = S_MEASURE;
      default:   state_d = S_ACQUIRE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    lvl_d   = lvl_q;
    valid_d = 1'b0;
    flag_d  = flag_q;
    case (state_q)
      S_ACQUIRE: begin
        if (edge_d) cnt_d = '0;
      end
      S_MEASURE: begin
        if (edge_d) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          hp_d    = elapsed;
          lvl_d   = level_q;
        end else begin
          cnt_d = elapsed;
          if (elapsed == TMO) flag_d = 1'b1;
        end
      end
      S_STALLED: begin
        if (edge_d) begin
          cnt_d  = '0;
          flag_d = 1'b0;
        end
      end
      default: begin
        cnt_d  = '0;
        flag_d = 1'b0;
      end
    endcase
  end

  assign HALF_PERIOD  = hp_q;
  assign LEVEL        = lvl_q;
  assign VALID        = valid_q;
  assign TIMEOUT_FLAG = flag_q;
  assign LED          = {flag_q, level_q};

endmodule
`default_nettype wire

// File: tb/tb_blink_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_blink_meter: scoreboard bench for blink_meter phase measurement
// rev 1.0
// ----------------------------------------------------------------------------
module tb_blink_meter;
  localparam int CNT_W   = 32;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 5000;

  logic             clk;
  logic             rst;
  logic             sig;
  logic [CNT_W-1:0] half_period;
  logic             level;
  logic             valid;
  logic             tflag;
  logic [1:0]       led;

  int tests = 0;
  int fails = 0;
  logic [CNT_W:0] exp_q[$];

  blink_meter #(.CNT_W(CNT_W), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .SIG_IN      (sig),
    .HALF_PERIOD (half_period),
    .LEVEL       (level),
    .VALID       (valid),
    .TIMEOUT_FLAG(tflag),
    .LED         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_phase(input logic lvl, input int n);
    exp_q.push_back({lvl, CNT_W'(n)});
  endtask

  // Hold SIG_IN at lvl for exactly n clock edges.
  task automatic drive(input logic lvl, input int n);
    sig = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Same as drive, and checks that LED[0] switches exactly 2+FILTER edges after the change.
  task automatic drive_led(input logic lvl, input int n);
    sig = lvl;
    repeat (FILTER + 1) @(posedge clk);
    #1 chk("led0_before_accept", 64'(led[0]), 64'(!lvl));
    @(posedge clk);
    #1 chk("led0_after_accept", 64'(led[0]), 64'(lvl));
    repeat (n - FILTER - 2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got level=%0d half_period=%0d, required no strobe (t=%0t)",
                 level, half_period, $time);
      end else begin
        logic [CNT_W:0] e;
        e = exp_q.pop_front();
        if ({level, half_period} !== e) begin
          fails++;
          $display("FAIL phase_report: got level=%0d half_period=%0d, required level=%0d half_period=%0d (t=%0t)",
                   level, half_period, e[CNT_W], e[CNT_W-1:0], $time);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    sig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_half_period", 64'(half_period), 64'd0);
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_flag", 64'(tflag), 64'd0);
    chk("reset_led", 64'(led), 64'd0);
    rst = 1'b0;
    drive(1'b0, 20);

    // 1000-cycle square wave; the first edge is not reported
    expect_phase(1'b1, 1000); drive_led(1'b1, 1000);
    expect_phase(1'b0, 1000); drive_led(1'b0, 1000);
    expect_phase(1'b1, 1000); drive_led(1'b1, 1000);
    expect_phase(1'b0, 1000); drive_led(1'b0, 1000);

    // asymmetric 300/700
    expect_phase(1'b1, 300); drive(1'b1, 300);
    expect_phase(1'b0, 700); drive(1'b0, 700);
    expect_phase(1'b1, 300); drive(1'b1, 300);
    expect_phase(1'b0, 700); drive(1'b0, 700);

    // 3-cycle glitch is rejected; 4-cycle pulse is accepted
    expect_phase(1'b1, 1000);
    drive(1'b1, 500); drive(1'b0, 3); drive(1'b1, 497);
    expect_phase(1'b0, 500); drive(1'b0, 500);
    expect_phase(1'b1, 4);   drive(1'b1, 4);
    expect_phase(1'b0, 496); drive(1'b0, 496);

    // phase of exactly TIMEOUT: reported, no stall
    expect_phase(1'b1, 5000); drive(1'b1, 5000);

    // stall: flag rises exactly TIMEOUT edges after the accepted edge
    drive(1'b0, 5005);
    chk("flag_before_timeout", 64'(tflag), 64'd0);
    drive(1'b0, 1);
    chk("flag_at_timeout", 64'(tflag), 64'd1);
    chk("led1_at_timeout", 64'(led[1]), 64'd1);
    drive(1'b0, 994);
    expect_phase(1'b1, 800);
    drive(1'b1, 5);
    chk("flag_before_clear", 64'(tflag), 64'd1);
    drive(1'b1, 1);
    chk("flag_cleared", 64'(tflag), 64'd0);
    drive(1'b1, 794);
    expect_phase(1'b0, 400); drive(1'b0, 400);
    drive(1'b1, 300);

    // asynchronous reset mid-measurement
    #1 rst = 1'b1;
    #1;
    chk("async_half_period", 64'(half_period), 64'd0);
    chk("async_level", 64'(level), 64'd0);
    chk("async_valid", 64'(valid), 64'd0);
    chk("async_flag", 64'(tflag), 64'd0);
    chk("async_led", 64'(led), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    drive(1'b0, 50); drive(1'b1, 50); drive(1'b0, 10);
    rst = 1'b0;
    drive(1'b0, 20);
    expect_phase(1'b1, 500); drive(1'b1, 500);
    drive(1'b0, 300);

    drive(1'b0, 20);
    chk("all_phases_reported", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
